wide_priority_encoder_seq: RTL and testbench
============================================

# wide_priority_encoder_seq

- Parametrised, multi-cycle successor to the fixed 32-to-5 single-cycle encoders in the garble benchmark set.
- Accepts a WIDTH-bit request vector over a valid/ready handshake and scans it CHUNK bits per clock.
- Returns the index of the lowest set bit plus a found flag over a second valid/ready handshake.
- Trades latency for a small per-cycle gate count, which is the figure of merit for sequential garbled evaluation.

## Interface

Parameters:
- WIDTH, 32, request vector width; must be a multiple of CHUNK and at least 2.
- CHUNK, 8, bits examined per cycle; must be a power of two.
- NCHUNK (derived, not overridable) = WIDTH/CHUNK.
- IDX_W (derived, not overridable) = clog2(WIDTH).

Ports:
- clk, input, 1, sole clock; all state changes on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, request vector present.
- in_ready, output, 1, block can accept a vector.
- in_data, input, WIDTH, request vector; bit 0 has highest priority.
- out_valid, output, 1, result present.
- out_ready, input, 1, consumer takes result.
- out_idx, output, IDX_W, index of lowest set bit; 0 when none.
- out_found, output, 1, at least one bit set.
- out_multi, output, 1, more than one bit set; present only with ENC_MULTIHOT_FLAG_EN.

## Operation

- FSM states: IDLE, SCAN, DONE.
- Registers: captured vector, chunk counter (clog2(NCHUNK) bits, minimum 1), idx, found, multi (macro only).
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_data, clear counter/found/idx/multi, go to SCAN.
- SCAN:
  - Each cycle examine bits [c*CHUNK +: CHUNK], where c is the counter.
  - If found=0 and the chunk is nonzero: idx = c*CHUNK + lowest set position within the chunk; found=1.
  - Without the macro: go to DONE on the first hit, or after chunk NCHUNK-1.
  - Otherwise counter increments.
- DONE:
  - out_valid=1; out_idx, out_found and out_multi are held stable until out_valid&out_ready.
  - On handshake with in_valid=0: go to IDLE.
  - in_ready = out_ready in DONE. Handshake plus in_valid=1 captures the new vector and goes directly to SCAN (back-to-back, no IDLE bubble).
- in_ready=0 in SCAN.
- in_data is ignored outside an in handshake; out_ready is ignored outside DONE.
- Index arithmetic is unsigned, IDX_W bits; out_idx can never exceed WIDTH-1.

## Timing

- Reset (rst_n low, asynchronous):
  - state=IDLE; out_valid=0, out_idx=0, out_found=0, out_multi=0.
  - in_ready is forced to 0 while rst_n is low and rises combinationally after release.
- Reset mid-SCAN or mid-DONE: the vector and result are discarded, no out handshake occurs, and the FSM restarts in IDLE.
- Latency without the macro, counted from the accepting edge to the edge after which out_valid=1:
  - c+1 cycles, where c is the first nonzero chunk.
  - NCHUNK cycles for an all-zero vector.
- Latency with the macro: always NCHUNK cycles.
- Throughput: one result per (latency+1) cycles with the consumer always ready; back-to-back acceptance in DONE removes the IDLE cycle.
- All outputs are registered except in_ready, which is combinational from state and out_ready.

## Configuration

- Macro: ENC_MULTIHOT_FLAG_EN.
- Defined:
  - out_multi port exists; SCAN always visits all NCHUNK chunks.
  - multi sets when a chunk has two or more set bits, or when a chunk is nonzero while found=1 from an earlier chunk.
  - Fixed latency keeps the garbled cost data-independent.
- Undefined: no out_multi port, no multi register, early termination on first hit.
- idx and found are identical in both builds.

## Test plan

(WIDTH=32, CHUNK=8 unless noted.)
- in_data=0x0000_0001, out_ready=1 -> out_idx=0, out_found=1, out_valid 1 cycle after accept (4 cycles with macro, out_multi=0).
- in_data=0x8000_0000 -> out_idx=31, out_found=1, latency 4 in both builds.
- in_data=0x0001_0100 -> out_idx=8, latency 2 without macro; with macro latency 4, out_multi=1. in_data=0x0000_0006 with macro -> out_idx=1, out_multi=1.
- in_data=0 -> out_found=0, out_idx=0, latency 4; repeat with WIDTH=64, CHUNK=16 -> latency 4, in_data=1<<63 gives out_idx=63.
- Hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0. Then out_ready=1 with in_valid=1 and 0x10 -> new vector accepted the same edge, next out_idx=4 with no IDLE cycle.
- Assert rst_n low during SCAN of 0x8000_0000 -> out_valid stays 0, outputs 0. After release, in_data=0x4 -> out_idx=2, out_found=1.

Source files
------------

// File: rtl/wide_priority_encoder_seq.sv
// Sequential lowest-set-bit encoder that scans the request vector CHUNK bits per clock (optional ENC_MULTIHOT_FLAG_EN adds out_multi).
// Latency: c+1 cycles to first nonzero chunk c (NCHUNK when empty); NCHUNK always with ENC_MULTIHOT_FLAG_EN.
// Backpressure: result is held in DONE until out_ready; in_ready follows out_ready there so a new vector can chain in.
module wide_priority_encoder_seq #(
    parameter  int WIDTH  = 32,
    parameter  int CHUNK  = 8,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int IDX_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
`ifdef ENC_MULTIHOT_FLAG_EN
    output logic             out_multi,
`endif
    output logic             out_found
);

    localparam int CNT_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int POS_W = (CHUNK > 1) ? $clog2(CHUNK) : 1;
    localparam int SHIFT = $clog2(CHUNK);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]                   state;
    logic [NCHUNK-1:0][CHUNK-1:0] vec;
    logic [CNT_W-1:0]             cnt;
    logic [IDX_W-1:0]             idx;
    logic                         found;
`ifdef ENC_MULTIHOT_FLAG_EN
    logic                         multi;
`endif

    logic [CHUNK-1:0] chunk;
    logic             chunk_nz;
    logic [POS_W-1:0] pos;
    logic [IDX_W-1:0] hit_idx;
    logic             accept;
    logic             scan_done;

    // Downward loop leaves pos at the lowest set bit of the current chunk.
    always_comb begin
        chunk    = vec[cnt];
        chunk_nz = |chunk;
        pos      = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (chunk[i]) begin
                pos = POS_W'(i);
            end
        end
    end

    // CHUNK is a power of two, so chunk base plus in-chunk offset is a shift and OR.
    assign hit_idx = (IDX_W'(cnt) << SHIFT) | IDX_W'(pos);

`ifdef ENC_MULTIHOT_FLAG_EN
    assign scan_done = (cnt == LAST_CNT);
`else
    assign scan_done = (cnt == LAST_CNT) || (chunk_nz && !found);
`endif

    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            case (state)
                ST_IDLE: in_ready = 1'b1;
                ST_DONE: in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            vec   <= '0;
            cnt   <= '0;
            idx   <= '0;
            found <= 1'b0;
`ifdef ENC_MULTIHOT_FLAG_EN
            multi <= 1'b0;
`endif
        end else if (accept) begin
            state <= ST_SCAN;
            vec   <= in_data;
            cnt   <= '0;
            idx   <= '0;
            found <= 1'b0;
`ifdef ENC_MULTIHOT_FLAG_EN
            multi <= 1'b0;
`endif
        end else begin
            case (state)
                ST_SCAN: begin
                    if (chunk_nz && !found) begin
                        idx   <= hit_idx;
                        found <= 1'b1;
                    end
`ifdef ENC_MULTIHOT_FLAG_EN
                    // A second hit is either two bits in this chunk or any bit after an earlier hit.
                    if ((chunk_nz && found) || (|(chunk & (chunk - CHUNK'(1))))) begin
                        multi <= 1'b1;
                    end
`endif
                    if (scan_done) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = (state == ST_DONE);
    assign out_idx   = idx;
    assign out_found = found;
`ifdef ENC_MULTIHOT_FLAG_EN
    assign out_multi = multi;
`endif

endmodule

// File: tb/tb_wide_priority_encoder_seq.sv
// Directed bench for wide_priority_encoder_seq: a 32/8 and a 64/16 instance on one clock.
module tb_wide_priority_encoder_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        v32 = 1'b0, r32 = 1'b1, ir32, ov32, of32;
    logic [31:0] d32 = '0;
    logic [4:0]  oi32;
    logic        v64 = 1'b0, r64 = 1'b1, ir64, ov64, of64;
    logic [63:0] d64 = '0;
    logic [5:0]  oi64;
`ifdef ENC_MULTIHOT_FLAG_EN
    logic        om32, om64;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wide_priority_encoder_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v32), .in_ready(ir32), .in_data(d32),
        .out_valid(ov32), .out_ready(r32), .out_idx(oi32),
`ifdef ENC_MULTIHOT_FLAG_EN
        .out_multi(om32),
`endif
        .out_found(of32)
    );

    wide_priority_encoder_seq #(.WIDTH(64), .CHUNK(16)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v64), .in_ready(ir64), .in_data(d64),
        .out_valid(ov64), .out_ready(r64), .out_idx(oi64),
`ifdef ENC_MULTIHOT_FLAG_EN
        .out_multi(om64),
`endif
        .out_found(of64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Multihot build scans every chunk, so latency is pinned to NCHUNK.
    function automatic int exp_lat(input int early, input int nchunk);
`ifdef ENC_MULTIHOT_FLAG_EN
        exp_lat = nchunk;
`else
        exp_lat = early;
`endif
    endfunction

    task automatic send(input bit big, input logic [63:0] vec);
        if (big) begin
            v64 = 1'b1;
            d64 = vec;
        end else begin
            v32 = 1'b1;
            d32 = vec[31:0];
        end
        @(posedge clk); #1;
        v32 = 1'b0;
        v64 = 1'b0;
    endtask

    task automatic wait_result(input bit big, input string tag, output int lat);
        logic ov;
        lat = 0;
        ov  = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            lat++;
            ov = big ? ov64 : ov32;
            if (ov) break;
        end
        chk({tag, "_valid_seen"}, 64'(ov), 64'd1);
    endtask

    task automatic run(input bit big, input logic [63:0] vec, input int e_idx, input bit e_found,
                       input int e_lat, input bit e_multi, input string tag);
        int lat;
        chk({tag, "_in_ready"}, 64'(big ? ir64 : ir32), 64'd1);
        send(big, vec);
        wait_result(big, tag, lat);
        chk({tag, "_idx"}, big ? 64'(oi64) : 64'(oi32), 64'(e_idx));
        chk({tag, "_found"}, 64'(big ? of64 : of32), 64'(e_found));
        chk({tag, "_latency"}, 64'(lat), 64'(e_lat));
`ifdef ENC_MULTIHOT_FLAG_EN
        chk({tag, "_multi"}, 64'(big ? om64 : om32), 64'(e_multi));
`else
        if (e_multi) begin end
`endif
        @(posedge clk); #1;
        chk({tag, "_drained"}, 64'(big ? ov64 : ov32), 64'd0);
    endtask

    initial begin
        int lat;
        #1;
        chk("rst_in_ready", 64'(ir32), 64'd0);
        chk("rst_out_valid", 64'(ov32), 64'd0);
        chk("rst_out_idx", 64'(oi32), 64'd0);
        chk("rst_out_found", 64'(of32), 64'd0);
        #21;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(ir32), 64'd1);

        run(0, 64'h0000_0001,  0, 1'b1, exp_lat(1, 4), 1'b0, "bit0");
        run(0, 64'h8000_0000, 31, 1'b1, exp_lat(4, 4), 1'b0, "bit31");
        run(0, 64'h0001_0100,  8, 1'b1, exp_lat(2, 4), 1'b1, "bit8_16");
        run(0, 64'h0000_0006,  1, 1'b1, exp_lat(1, 4), 1'b1, "bits1_2");
        run(0, 64'h0010_0000, 20, 1'b1, exp_lat(3, 4), 1'b0, "bit20");
        run(0, 64'h0000_0000,  0, 1'b0, exp_lat(4, 4), 1'b0, "zero");

        run(1, 64'h0,                   0, 1'b0, exp_lat(4, 4), 1'b0, "w64_zero");
        run(1, 64'h8000_0000_0000_0000, 63, 1'b1, exp_lat(4, 4), 1'b0, "w64_bit63");
        run(1, 64'h0000_0000_0001_0000, 16, 1'b1, exp_lat(2, 4), 1'b0, "w64_bit16");

        // Consumer stalls, then releases with a new vector waiting.
        r32 = 1'b0;
        send(0, 64'h0000_0100);
        wait_result(0, "bp", lat);
        chk("bp_latency", 64'(lat), 64'(exp_lat(2, 4)));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(ov32), 64'd1);
            chk("bp_out_idx", 64'(oi32), 64'd8);
            chk("bp_out_found", 64'(of32), 64'd1);
            chk("bp_in_ready", 64'(ir32), 64'd0);
        end
        r32 = 1'b1;
        v32 = 1'b1;
        d32 = 32'h0000_0010;
        #1;
        chk("b2b_in_ready", 64'(ir32), 64'd1);
        @(posedge clk); #1;
        v32 = 1'b0;
        chk("b2b_out_valid_drop", 64'(ov32), 64'd0);
        chk("b2b_scan_in_ready", 64'(ir32), 64'd0);
        wait_result(0, "b2b", lat);
        chk("b2b_idx", 64'(oi32), 64'd4);
        chk("b2b_latency", 64'(lat), 64'(exp_lat(1, 4)));
        @(posedge clk); #1;

        // Reset in the middle of a scan discards the vector.
        send(0, 64'h8000_0000);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(ov32), 64'd0);
        chk("mid_rst_out_idx", 64'(oi32), 64'd0);
        chk("mid_rst_out_found", 64'(of32), 64'd0);
        chk("mid_rst_in_ready", 64'(ir32), 64'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("mid_rst_hold_valid", 64'(ov32), 64'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("mid_rst_release_in_ready", 64'(ir32), 64'd1);
        @(posedge clk); #1;
        chk("mid_rst_idle_valid", 64'(ov32), 64'd0);
        run(0, 64'h0000_0004, 2, 1'b1, exp_lat(1, 4), 1'b0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
